mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Parametrised control unit for the multicycle MIPS datapath. It decodes the opcode latched in the instruction register and sequences the datapath select and enable lines (PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst). Compared with hard-wired select registers, it adds three things:
- a memory wait handshake;
- optional immediate-ALU instructions;
- an illegal-opcode trap with a retired-instruction counter.

Parameters:
USE_MEM_READY, 1, 1: memory accesses stall until mem_ready=1; 0: mem_ready ignored, all accesses complete in one cycle.
IMM_EN, 1, 1: addi (001000) and ori (001101) are legal; 0: they trap as illegal.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
mem_ready  input  1  memory completed current read/write this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
PCSource, ALUOp, ALUSrcB  output  2 each  mux selects and ALU op class (00 add, 01 sub, 10 funct, 11 or)
state  output  4  current state encoding (debug)
trap  output  1  illegal opcode seen; sticky until reset
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset:
  - While rst_n=0: state=FETCH (0), trap=0, retired=0, and every control output is forced to 0 regardless of state.
  - Deassertion takes effect at the next rising edge of clk.
- State encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RCOMP 7, BRANCH 8, JUMP 9, IEXEC 10, ICOMP 11, TRAP 12.
- Outputs are decoded from state. The exception is that PCWrite and IRWrite in FETCH are qualified by the memory-done term. Unlisted controls are 0 in each state.
- Memory-done term `done` = mem_ready when USE_MEM_READY=1, otherwise constant 1.
- Per-state outputs and transitions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=done. Stay while !done; else go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
    - 100011 or 101011 -> MEMADDR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 or 001101 -> IEXEC if IMM_EN, else TRAP
    - anything else -> TRAP
  - MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if lw, MEMWR if sw.
  - MEMRD: MemRead=1, IorD=1. Hold until done, then MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
  - MEMWR: MemWrite=1, IorD=1. Hold until done, then FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RCOMP.
  - RCOMP: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
  - JUMP: PCWrite=1, PCSource=10. Go to FETCH.
  - IEXEC: ALUSrcA=1, ALUSrcB=10; ALUOp=00 for addi, 11 for ori. Go to ICOMP.
  - ICOMP: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
  - TRAP: all controls 0, trap=1. Stays in TRAP until reset; the FSM issues no further memory traffic.
- Retirement:
  - retired increments by 1 on the clock edge that leaves MEMWB, MEMWR (when done), RCOMP, BRANCH, JUMP or ICOMP.
  - The counter wraps modulo 2^CNT_W; all-ones +1 = 0.
- Opcode sampling: opcode is sampled only in DECODE and in MEMADDR/IEXEC. The datapath holds IR stable because IRWrite=0 outside FETCH.
- Latency with done=1: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3 cycles. Each wait cycle adds one cycle in FETCH, MEMRD or MEMWR.
- A reset asserted mid-instruction aborts it immediately; the counter does not increment.
- mem_ready asserted outside FETCH/MEMRD/MEMWR is ignored.

Test Plan:
- Reset then lw (100011), mem_ready tied 1: states 0,1,2,3,4,0; MemWB cycle has RegWrite=1, MemtoReg=1; retired=1 after 5 cycles.
- sw (101011) with mem_ready low for 3 cycles in MEMWR: MemWrite=1, IorD=1 held 4 cycles; retired increments only on the cycle mem_ready=1.
- R-type then beq then j back-to-back: ALUOp 10 in EXEC, RegDst=1 in RCOMP; PCWriteCond=1/PCSource=01 in BRANCH; PCWrite=1/PCSource=10 in JUMP; retired=3 after 10 cycles.
- IMM_EN=1: ori (001101) gives ALUOp=11, ALUSrcB=10 in IEXEC. IMM_EN=0: same opcode gives state=12, trap=1, with all controls 0 for 20 further cycles.
- Opcode 111111: trap=1 after DECODE; assert rst_n=0 gives trap=0, retired=0 and all outputs 0 asynchronously; after release, FETCH resumes.
- CNT_W=4: retire 16 jumps; retired goes 15 -> 0. Also drop rst_n in MEMRD: no increment, state 0 on release.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory wait handshake,
// optional immediate ALU ops, illegal-opcode trap and retire counter.
module mips_multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit IMM_EN        = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RCOMP   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    IEXEC   = 4'd10,
    ICOMP   = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           curState;
  logic             trapReg;
  logic [CNT_W-1:0] retiredReg;
  logic             done;

  logic isMem;
  logic isR;
  logic isBeq;
  logic isJ;
  logic isImm;

  assign done  = USE_MEM_READY ? mem_ready : 1'b1;

  assign isMem = (opcode == OP_LW) || (opcode == OP_SW);
  assign isR   = (opcode == OP_R);
  assign isBeq = (opcode == OP_BEQ);
  assign isJ   = (opcode == OP_J);
  assign isImm = IMM_EN &&
                 ((opcode == OP_ADDI) || (opcode == OP_ORI));

  assign state   = curState;
  assign trap    = trapReg;
  assign retired = retiredReg;

  // State sequencing, sticky trap flag and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState   <= FETCH;
      trapReg    <= 1'b0;
      retiredReg <= '0;
    end else begin
      case (curState)
        FETCH: begin
          if (done) curState <= DECODE;
        end
        DECODE: begin
          unique case (1'b1)
            isMem:   curState <= MEMADDR;
            isR:     curState <= EXEC;
            isBeq:   curState <= BRANCH;
            isJ:     curState <= JUMP;
            isImm:   curState <= IEXEC;
            default: begin
              curState <= TRAP;
              trapReg  <= 1'b1;
            end
          endcase
        end
        MEMADDR: begin
          curState <= (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          if (done) curState <= MEMWB;
        end
        MEMWB: begin
          curState   <= FETCH;
          retiredReg <= retiredReg + ONE;
        end
        MEMWR: begin
          if (done) begin
            curState   <= FETCH;
            retiredReg <= retiredReg + ONE;
          end
        end
        EXEC: begin
          curState <= RCOMP;
        end
        RCOMP, BRANCH, JUMP, ICOMP: begin
          curState   <= FETCH;
          retiredReg <= retiredReg + ONE;
        end
        IEXEC: begin
          curState <= ICOMP;
        end
        TRAP: begin
          curState <= TRAP;
          trapReg  <= 1'b1;
        end
        default: begin
          curState <= FETCH;
        end
      endcase
    end
  end

  // Datapath controls decoded from state, all held low in reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    if (rst_n) begin
      case (curState)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = done;
          PCWrite = done;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
        end
        MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RCOMP: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = (opcode == OP_ORI) ? 2'b11 : 2'b00;
        end
        ICOMP: begin
          RegWrite = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: default build (A)
// and a no-wait, no-immediate, 4-bit-counter build (B).
`timescale 1ns/1ps
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rstA, mrA;
  logic [5:0] opA;
  logic       pcwA, pcwcA, iordA, mrdA, mwrA, m2rA, irwA, asaA, rwA, rdA;
  logic [1:0] pcsA, aluA, asbA;
  logic [3:0] stA;
  logic       trA;
  logic [31:0] retA;
  logic [15:0] ctlA;

  logic       rstB, mrB;
  logic [5:0] opB;
  logic       pcwB, pcwcB, iordB, mrdB, mwrB, m2rB, irwB, asaB, rwB, rdB;
  logic [1:0] pcsB, aluB, asbB;
  logic [3:0] stB;
  logic       trB;
  logic [3:0] retB;
  logic [15:0] ctlB;

  mips_multicycle_control dutA (
    .clk(clk), .rst_n(rstA), .opcode(opA), .mem_ready(mrA),
    .PCWrite(pcwA), .PCWriteCond(pcwcA), .IorD(iordA),
    .MemRead(mrdA), .MemWrite(mwrA), .MemtoReg(m2rA),
    .IRWrite(irwA), .ALUSrcA(asaA), .RegWrite(rwA),
    .RegDst(rdA), .PCSource(pcsA), .ALUOp(aluA),
    .ALUSrcB(asbA), .state(stA), .trap(trA), .retired(retA)
  );

  mips_multicycle_control #(
    .USE_MEM_READY(1'b0), .IMM_EN(1'b0), .CNT_W(4)
  ) dutB (
    .clk(clk), .rst_n(rstB), .opcode(opB), .mem_ready(mrB),
    .PCWrite(pcwB), .PCWriteCond(pcwcB), .IorD(iordB),
    .MemRead(mrdB), .MemWrite(mwrB), .MemtoReg(m2rB),
    .IRWrite(irwB), .ALUSrcA(asaB), .RegWrite(rwB),
    .RegDst(rdB), .PCSource(pcsB), .ALUOp(aluB),
    .ALUSrcB(asbB), .state(stB), .trap(trB), .retired(retB)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,
  //  IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUOp,ALUSrcB}
  assign ctlA = {pcwA, pcwcA, iordA, mrdA, mwrA, m2rA,
                 irwA, asaA, rwA, rdA, pcsA, aluA, asbA};
  assign ctlB = {pcwB, pcwcB, iordB, mrdB, mwrB, m2rB,
                 irwB, asaB, rwB, rdB, pcsB, aluB, asbB};

  localparam logic [15:0] C_FETCH = 16'h9201;
  localparam logic [15:0] C_DEC   = 16'h0003;
  localparam logic [15:0] C_MADDR = 16'h0102;
  localparam logic [15:0] C_MRD   = 16'h3000;
  localparam logic [15:0] C_MWB   = 16'h0480;
  localparam logic [15:0] C_MWR   = 16'h2800;
  localparam logic [15:0] C_EXEC  = 16'h0108;
  localparam logic [15:0] C_RCOMP = 16'h00C0;
  localparam logic [15:0] C_BR    = 16'h4114;
  localparam logic [15:0] C_JUMP  = 16'h8020;
  localparam logic [15:0] C_ORI   = 16'h010E;
  localparam logic [15:0] C_ADDI  = 16'h0102;
  localparam logic [15:0] C_ICOMP = 16'h0080;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, BAD = 6'b111111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstA = 1'b0; rstB = 1'b0;
    opA = LW; opB = ORI; mrA = 1'b1; mrB = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stA !== 4'd0 || ctlA !== 16'h0 || trA !== 1'b0 || retA !== 32'd0) begin
        errors++;
        $display("FAIL reset_A st=%0d ctl=%h trap=%b ret=%0d want 0/0000/0/0",
                 stA, ctlA, trA, retA);
      end
      checks++;
      if (stB !== 4'd0 || ctlB !== 16'h0 || trB !== 1'b0 || retB !== 4'd0) begin
        errors++;
        $display("FAIL reset_B st=%0d ctl=%h trap=%b ret=%0d want 0/0000/0/0",
                 stB, ctlB, trB, retB);
      end
      tick();
    end
  endtask

  task automatic test_lw();
    logic [3:0]  expSt[6];
    logic [15:0] expCtl[6];
    expSt  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    expCtl = '{C_FETCH, C_DEC, C_MADDR, C_MRD, C_MWB, C_FETCH};
    @(negedge clk);
    rstA = 1'b1; opA = LW; mrA = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (stA !== expSt[i] || ctlA !== expCtl[i]) begin
        errors++;
        $display("FAIL lw_step%0d st=%0d ctl=%h want %0d/%h",
                 i, stA, ctlA, expSt[i], expCtl[i]);
      end
    end
    checks++;
    if (retA !== 32'd1) begin
      errors++;
      $display("FAIL lw_retired got %0d want 1", retA);
    end
  endtask

  task automatic test_sw();
    opA = SW;
    tick(); tick(); tick();
    mrA = 1'b0;
    #1;
    checks++;
    if (stA !== 4'd5 || ctlA !== C_MWR || retA !== 32'd1) begin
      errors++;
      $display("FAIL sw_enter st=%0d ctl=%h ret=%0d want 5/%h/1",
               stA, ctlA, retA, C_MWR);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (stA !== 4'd5 || ctlA !== C_MWR || retA !== 32'd1) begin
        errors++;
        $display("FAIL sw_wait%0d st=%0d ctl=%h ret=%0d want 5/%h/1",
                 i, stA, ctlA, retA, C_MWR);
      end
    end
    mrA = 1'b1;
    tick();
    checks++;
    if (stA !== 4'd0 || retA !== 32'd2) begin
      errors++;
      $display("FAIL sw_done st=%0d ret=%0d want 0/2", stA, retA);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops[10];
    logic [3:0]  expSt[10];
    logic [15:0] expCtl[10];
    ops    = '{RT, RT, RT, RT, BEQ, BEQ, BEQ, JMP, JMP, JMP};
    expSt  = '{4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8, 4'd0,
               4'd1, 4'd9, 4'd0};
    expCtl = '{C_DEC, C_EXEC, C_RCOMP, C_FETCH, C_DEC, C_BR,
               C_FETCH, C_DEC, C_JUMP, C_FETCH};
    for (int i = 0; i < 10; i++) begin
      opA = ops[i];
      tick();
      checks++;
      if (stA !== expSt[i] || ctlA !== expCtl[i]) begin
        errors++;
        $display("FAIL b2b_step%0d st=%0d ctl=%h want %0d/%h",
                 i, stA, ctlA, expSt[i], expCtl[i]);
      end
    end
    checks++;
    if (retA !== 32'd5) begin
      errors++;
      $display("FAIL b2b_retired got %0d want 5", retA);
    end
  endtask

  task automatic test_imm();
    logic [5:0]  ops[8];
    logic [3:0]  expSt[8];
    logic [15:0] expCtl[8];
    ops    = '{ORI, ORI, ORI, ORI, ADDI, ADDI, ADDI, ADDI};
    expSt  = '{4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    expCtl = '{C_DEC, C_ORI, C_ICOMP, C_FETCH, C_DEC, C_ADDI,
               C_ICOMP, C_FETCH};
    for (int i = 0; i < 8; i++) begin
      opA = ops[i];
      tick();
      checks++;
      if (stA !== expSt[i] || ctlA !== expCtl[i]) begin
        errors++;
        $display("FAIL imm_step%0d st=%0d ctl=%h want %0d/%h",
                 i, stA, ctlA, expSt[i], expCtl[i]);
      end
    end
    checks++;
    if (retA !== 32'd7 || trA !== 1'b0) begin
      errors++;
      $display("FAIL imm_retired ret=%0d trap=%b want 7/0", retA, trA);
    end
  endtask

  task automatic test_illegal();
    opA = BAD;
    tick(); tick();
    checks++;
    if (stA !== 4'd12 || trA !== 1'b1 || ctlA !== 16'h0) begin
      errors++;
      $display("FAIL illegal_trap st=%0d trap=%b ctl=%h want 12/1/0000",
               stA, trA, ctlA);
    end
    tick();
    checks++;
    if (stA !== 4'd12 || trA !== 1'b1 || ctlA !== 16'h0) begin
      errors++;
      $display("FAIL illegal_hold st=%0d trap=%b ctl=%h want 12/1/0000",
               stA, trA, ctlA);
    end
    #2 rstA = 1'b0;
    #1;
    checks++;
    if (stA !== 4'd0 || trA !== 1'b0 || retA !== 32'd0 || ctlA !== 16'h0) begin
      errors++;
      $display("FAIL illegal_async_rst st=%0d trap=%b ret=%0d ctl=%h want 0/0/0/0000",
               stA, trA, retA, ctlA);
    end
    @(negedge clk);
    rstA = 1'b1; opA = LW; mrA = 1'b1;
    #1;
    checks++;
    if (stA !== 4'd0 || ctlA !== C_FETCH || trA !== 1'b0) begin
      errors++;
      $display("FAIL illegal_release st=%0d ctl=%h trap=%b want 0/%h/0",
               stA, ctlA, trA, C_FETCH);
    end
    tick();
    checks++;
    if (stA !== 4'd1) begin
      errors++;
      $display("FAIL illegal_resume st=%0d want 1", stA);
    end
  endtask

  task automatic test_rst_memrd();
    tick();
    mrA = 1'b0;
    tick(); tick();
    checks++;
    if (stA !== 4'd3 || ctlA !== C_MRD) begin
      errors++;
      $display("FAIL memrd_hold st=%0d ctl=%h want 3/%h", stA, ctlA, C_MRD);
    end
    mrA = 1'b1;
    #2 rstA = 1'b0;
    #1;
    checks++;
    if (stA !== 4'd0 || retA !== 32'd0 || ctlA !== 16'h0) begin
      errors++;
      $display("FAIL memrd_rst st=%0d ret=%0d ctl=%h want 0/0/0000",
               stA, retA, ctlA);
    end
    @(negedge clk);
    rstA = 1'b1;
    #1;
    checks++;
    if (stA !== 4'd0 || retA !== 32'd0) begin
      errors++;
      $display("FAIL memrd_release st=%0d ret=%0d want 0/0", stA, retA);
    end
    tick();
    checks++;
    if (stA !== 4'd1) begin
      errors++;
      $display("FAIL memrd_resume st=%0d want 1", stA);
    end
  endtask

  task automatic test_noimm();
    @(negedge clk);
    rstB = 1'b1; opB = ORI; mrB = 1'b0;
    #1;
    checks++;
    if (stB !== 4'd0 || ctlB !== C_FETCH) begin
      errors++;
      $display("FAIL noimm_fetch st=%0d ctl=%h want 0/%h", stB, ctlB, C_FETCH);
    end
    tick(); tick();
    checks++;
    if (stB !== 4'd12 || trB !== 1'b1 || ctlB !== 16'h0) begin
      errors++;
      $display("FAIL noimm_trap st=%0d trap=%b ctl=%h want 12/1/0000",
               stB, trB, ctlB);
    end
    for (int i = 0; i < 20; i++) begin
      mrB = i[0];
      tick();
      checks++;
      if (stB !== 4'd12 || trB !== 1'b1 || ctlB !== 16'h0) begin
        errors++;
        $display("FAIL noimm_hold%0d st=%0d trap=%b ctl=%h want 12/1/0000",
                 i, stB, trB, ctlB);
      end
    end
    rstB = 1'b0;
    #1;
    checks++;
    if (stB !== 4'd0 || trB !== 1'b0 || retB !== 4'd0 || ctlB !== 16'h0) begin
      errors++;
      $display("FAIL noimm_rst st=%0d trap=%b ret=%0d ctl=%h want 0/0/0/0000",
               stB, trB, retB, ctlB);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] expRet;
    @(negedge clk);
    rstB = 1'b1; opB = JMP; mrB = 1'b0;
    expRet = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick(); tick();
      if (i == 0) begin
        checks++;
        if (stB !== 4'd9 || ctlB !== C_JUMP) begin
          errors++;
          $display("FAIL wrap_jump st=%0d ctl=%h want 9/%h", stB, ctlB, C_JUMP);
        end
      end
      tick();
      expRet = expRet + 4'd1;
      checks++;
      if (retB !== expRet || stB !== 4'd0) begin
        errors++;
        $display("FAIL wrap_j%0d ret=%0d st=%0d want %0d/0",
                 i, retB, stB, expRet);
      end
    end
    checks++;
    if (retB !== 4'd0) begin
      errors++;
      $display("FAIL wrap_final ret=%0d want 0", retB);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_imm();
    test_illegal();
    test_rst_memrd();
    test_noimm();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
